// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one AXI controller port between icache and dcache.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin instead of dcache-first priority.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_done,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_load,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_store,
    input  logic              d_done,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_load,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_store,
    output logic              m_done,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_load
);

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT_I = 2'b01,
        ARB_GRANT_D = 2'b10
    } arb_state_t;

    arb_state_t state_r;
    logic       i_pend_s;
    logic       d_pend_s;
    logic       pick_d_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // 1'b0 = icache won last, 1'b1 = dcache won last
    logic       last_grant_r;
`endif

    // Pending requests and the winner should a grant be issued from IDLE
    always_comb begin
        i_pend_s = i_read;
        d_pend_s = d_read | d_write;
        if (i_pend_s && d_pend_s) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick_d_s = ~last_grant_r;
`else
            pick_d_s = 1'b1;
`endif
        end else begin
            pick_d_s = d_pend_s;
        end
    end

    // Grant state machine: a grant is held until done+ready or the owner drops its request
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r <= ARB_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (i_pend_s || d_pend_s) begin
                        state_r <= pick_d_s ? ARB_GRANT_D : ARB_GRANT_I;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_r <= pick_d_s;
`endif
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_GRANT_I: begin
                    if ((i_done && m_ready) || !i_pend_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_GRANT_I;
                    end
                end
                ARB_GRANT_D: begin
                    if ((d_done && m_ready) || !d_pend_s) begin
                        state_r <= ARB_IDLE;
                    end else begin
                        state_r <= ARB_GRANT_D;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                end
            endcase
        end
    end

    // Port steering; the non-granted side sees ready=0 and load=0
    always_comb begin
        m_read  = 1'b0;
        m_write = 1'b0;
        m_addr  = {ADDR_W{1'b0}};
        m_store = {DATA_W{1'b0}};
        m_done  = 1'b0;
        i_ready = 1'b0;
        i_load  = {DATA_W{1'b0}};
        d_ready = 1'b0;
        d_load  = {DATA_W{1'b0}};
        case (state_r)
            ARB_GRANT_I: begin
                m_read  = i_read;
                m_addr  = i_addr;
                m_done  = i_done & m_ready;
                i_ready = m_ready;
                i_load  = m_load;
            end
            ARB_GRANT_D: begin
                m_read  = d_read;
                m_write = d_write;
                m_addr  = d_addr;
                m_store = d_store;
                m_done  = d_done & m_ready;
                d_ready = m_ready;
                d_load  = m_load;
            end
            default: begin
                m_done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level owner model checked every cycle,
// plus literal expectations taken from the test plan.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_read = 1'b0, i_done = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_ready;
    logic [31:0] i_load;
    logic        d_read = 1'b0, d_write = 1'b0, d_done = 1'b0;
    logic [31:0] d_addr = 32'h0, d_store = 32'h0;
    logic        d_ready;
    logic [31:0] d_load;
    logic        m_read, m_write, m_done;
    logic [31:0] m_addr, m_store;
    logic        m_ready = 1'b0;
    logic [31:0] m_load = 32'h0;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // owner: 0 = nobody, 1 = icache, 2 = dcache; last: who won the previous arbitration
    int owner = 0;
    int last = 1;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .i_read(i_read), .i_addr(i_addr), .i_done(i_done), .i_ready(i_ready), .i_load(i_load),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_store(d_store),
        .d_done(d_done), .d_ready(d_ready), .d_load(d_load),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_store(m_store),
        .m_done(m_done), .m_ready(m_ready), .m_load(m_load)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the port after each clock edge
    always @(posedge clk) begin
        if (!nrst) begin
            owner = 0;
            last = 1;
        end else if (owner == 0) begin
            if (i_read && (d_read || d_write)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                owner = (last == 1) ? 2 : 1;
`else
                owner = 2;
`endif
            end else if (d_read || d_write) begin
                owner = 2;
            end else if (i_read) begin
                owner = 1;
            end
            if (owner != 0) last = owner;
        end else if (owner == 1) begin
            if ((i_done && m_ready) || !i_read) owner = 0;
        end else begin
            if ((d_done && m_ready) || !(d_read || d_write)) owner = 0;
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic        e_mr, e_mw, e_md, e_ir, e_dr;
        logic [31:0] e_ma, e_ms, e_il, e_dl;
        if (chk_en) begin
            e_mr = 1'b0; e_mw = 1'b0; e_md = 1'b0; e_ir = 1'b0; e_dr = 1'b0;
            e_ma = 32'h0; e_ms = 32'h0; e_il = 32'h0; e_dl = 32'h0;
            if (owner == 1) begin
                e_mr = i_read; e_ma = i_addr; e_md = i_done & m_ready;
                e_ir = m_ready; e_il = m_load;
            end else if (owner == 2) begin
                e_mr = d_read; e_mw = d_write; e_ma = d_addr; e_ms = d_store;
                e_md = d_done & m_ready; e_dr = m_ready; e_dl = m_load;
            end
            chk("m_read", {31'h0, m_read}, {31'h0, e_mr});
            chk("m_write", {31'h0, m_write}, {31'h0, e_mw});
            chk("m_addr", m_addr, e_ma);
            chk("m_store", m_store, e_ms);
            chk("m_done", {31'h0, m_done}, {31'h0, e_md});
            chk("i_ready", {31'h0, i_ready}, {31'h0, e_ir});
            chk("i_load", i_load, e_il);
            chk("d_ready", {31'h0, d_ready}, {31'h0, e_dr});
            chk("d_load", d_load, e_dl);
        end
    end

    // Illegal simultaneous dcache read and write
    always @(negedge clk) begin
        if (nrst) begin
            assert (!(d_read && d_write)) else $error("dcache read and write both high");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_all();
        i_read = 1'b0; i_done = 1'b0; d_read = 1'b0; d_write = 1'b0; d_done = 1'b0;
        m_ready = 1'b0; m_load = 32'h0;
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        nrst = 1'b1;
        m_ready = 1'b1; m_load = 32'hCAFE_0001;
        settle();
        chk("reset_m_read", {31'h0, m_read}, 32'h0);
        chk("reset_i_ready", {31'h0, i_ready}, 32'h0);
        chk("reset_d_load", d_load, 32'h0);
        m_ready = 1'b0; m_load = 32'h0;

        // icache-only read
        i_read = 1'b1; i_addr = 32'h0000_1000;
        settle();
        chk("i_latency_idle", {31'h0, m_read}, 32'h0);
        tick();
        settle();
        chk("i_m_read", {31'h0, m_read}, 32'h1);
        chk("i_m_addr", m_addr, 32'h0000_1000);
        tick();
        m_ready = 1'b1; m_load = 32'hDEAD_BEEF; i_done = 1'b1;
        settle();
        chk("i_load", i_load, 32'hDEAD_BEEF);
        chk("i_ready", {31'h0, i_ready}, 32'h1);
        chk("i_m_done", {31'h0, m_done}, 32'h1);
        tick();
        i_done = 1'b0;
        settle();
        chk("i_idle_after_done", {31'h0, m_read}, 32'h0);
        chk("i_idle_ready", {31'h0, i_ready}, 32'h0);
        clear_all();
        tick();

        // dcache write
        d_write = 1'b1; d_addr = 32'h0000_2004; d_store = 32'h1234_5678;
        tick();
        settle();
        chk("d_m_write", {31'h0, m_write}, 32'h1);
        chk("d_m_store", m_store, 32'h1234_5678);
        chk("d_m_addr", m_addr, 32'h0000_2004);
        m_ready = 1'b1;
        settle();
        chk("d_ready", {31'h0, d_ready}, 32'h1);
        chk("d_i_ready", {31'h0, i_ready}, 32'h0);
        d_done = 1'b1;
        tick();
        clear_all();
        tick();

        // Simultaneous after a dcache win: round-robin picks icache, fixed picks dcache
        i_read = 1'b1; i_addr = 32'h0000_7000; d_read = 1'b1; d_addr = 32'h0000_8000;
        tick();
        settle();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("sim_after_d", m_addr, 32'h0000_7000);
`else
        chk("sim_after_d", m_addr, 32'h0000_8000);
`endif
        m_ready = 1'b1; i_done = 1'b1; d_done = 1'b1;
        tick();
        clear_all();
        tick();

        // Simultaneous after reset: dcache first, then icache after one idle cycle
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        i_read = 1'b1; i_addr = 32'h0000_3000; d_read = 1'b1; d_addr = 32'h0000_4000;
        tick();
        settle();
        chk("sim_first_d", m_addr, 32'h0000_4000);
        m_ready = 1'b1; d_done = 1'b1;
        tick();
        d_read = 1'b0; d_done = 1'b0; m_ready = 1'b0;
        settle();
        chk("sim_gap_idle", {31'h0, m_read}, 32'h0);
        tick();
        settle();
        chk("sim_then_i", m_addr, 32'h0000_3000);
        m_ready = 1'b1; i_done = 1'b1;
        tick();
        clear_all();
        tick();

        // Hold: icache request mid-dcache transaction waits
        d_read = 1'b1; d_addr = 32'h0000_5000;
        tick();
        i_read = 1'b1; i_addr = 32'h0000_6000;
        tick();
        settle();
        chk("hold_addr", m_addr, 32'h0000_5000);
        tick();
        m_ready = 1'b1; d_done = 1'b1;
        settle();
        chk("hold_addr_done", m_addr, 32'h0000_5000);
        tick();
        d_read = 1'b0; d_done = 1'b0; m_ready = 1'b0;
        tick();
        settle();
        chk("hold_then_i", m_addr, 32'h0000_6000);

        // Abort: icache drops its request before ready, pending dcache write follows
        i_read = 1'b0; d_write = 1'b1; d_addr = 32'h0000_9000; d_store = 32'h0BAD_F00D;
        settle();
        chk("abort_no_done", {31'h0, m_done}, 32'h0);
        tick();
        settle();
        chk("abort_idle", {31'h0, m_write}, 32'h0);
        tick();
        settle();
        chk("abort_then_d", {31'h0, m_write}, 32'h1);
        chk("abort_then_d_store", m_store, 32'h0BAD_F00D);
        d_write = 1'b0;
        tick();
        clear_all();
        tick();

        // Reset mid-transaction
        i_read = 1'b1; i_addr = 32'h0000_A000;
        tick();
        settle();
        chk("rst_mid_active", {31'h0, m_read}, 32'h1);
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        settle();
        chk("rst_mid_idle", {31'h0, m_read}, 32'h0);
        tick();
        settle();
        chk("rst_mid_regrant", {31'h0, m_read}, 32'h1);
        m_ready = 1'b1; i_done = 1'b1;
        tick();
        i_done = 1'b0; m_ready = 1'b0;
        // Same-requester repeat: i_read stays high, one idle cycle, then regrant
        settle();
        chk("repeat_idle", {31'h0, m_read}, 32'h0);
        tick();
        settle();
        chk("repeat_regrant", {31'h0, m_read}, 32'h1);
        clear_all();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
